// File: rtl/bpsk_awgn_mapper_nlane_pkg.sv
// Shared definitions for the BPSK mapper / AWGN adder: state encoding,
// the fixed-point +1.0 constant and the saturating adder used by the
// optional saturation build (MOD_SAT_EN).
package mod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // +1.0 in a SAMPLE_W-bit two's complement word with FRAC_W fraction bits;
    // yields 0 when the word has no room for a positive +1.0.
    function automatic int ONE_FIX(input int frac_w, input int sample_w);
        return (sample_w >= frac_w + 2) ? (1 << frac_w) : 0;
    endfunction

    // Signed add clamped to the range of a w-bit two's complement word.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int                 w);
        longint sum;
        longint hi;
        longint lo;
        sum = longint'(a) + longint'(b);
        hi  = (longint'(1) << (w - 1)) - longint'(1);
        lo  = -(longint'(1) << (w - 1));
        if (sum > hi) begin
            sum = hi;
        end
        if (sum < lo) begin
            sum = lo;
        end
        return 32'(sum);
    endfunction

endpackage

// File: rtl/bpsk_awgn_mapper_nlane_lane.sv
// bpsk_lane: one codeword bit plus one noise sample -> one channel sample.
// Purely combinational. MOD_SAT_EN selects a saturating sum; otherwise the
// sum wraps modulo 2^SAMPLE_W.
module bpsk_lane
    import mod_pkg::*;
#(
    parameter int SAMPLE_W = 15,
    parameter int FRAC_W   = 10
) (
    input  logic                code_bit,
    input  logic [SAMPLE_W-1:0] noise,
    output logic [SAMPLE_W-1:0] sample
);

    localparam logic [SAMPLE_W-1:0] POS_ONE = SAMPLE_W'(ONE_FIX(FRAC_W, SAMPLE_W));
    localparam logic [SAMPLE_W-1:0] NEG_ONE = SAMPLE_W'(-ONE_FIX(FRAC_W, SAMPLE_W));

    logic [SAMPLE_W-1:0] symbol;

    // Map bit 0 -> +1.0, bit 1 -> -1.0 and add the noise sample.
    always_comb begin
        symbol = code_bit ? NEG_ONE : POS_ONE;
`ifdef MOD_SAT_EN
        sample = SAMPLE_W'(sat_add(32'($signed(symbol)), 32'($signed(noise)), SAMPLE_W));
`else
        sample = symbol + noise;
`endif
    end

endmodule

// File: rtl/bpsk_awgn_mapper_nlane.sv
// BPSK mapper + AWGN adder, LANES samples per beat, between the LDPC encoder
// and the channel-sample RAM. Latches a codeword, streams noisy samples into
// the RAM whenever noise_valid is high, then hands the frame to the
// demodulator and counts completed frames.
// Optional feature: define MOD_SAT_EN for saturating sample sums.
module bpsk_awgn_mapper_nlane
    import mod_pkg::*;
#(
    parameter int CODE_LEN      = 256,
    parameter int CODE_LEN_BITS = 8,
    parameter int LANES         = 2,
    parameter int SAMPLE_W      = 15,
    parameter int FRAC_W        = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        code_valid,
    input  logic [CODE_LEN-1:0]         code_data,
    output logic                        code_ready,
    input  logic                        noise_valid,
    input  logic [LANES*SAMPLE_W-1:0]   noise_data,
    output logic [LANES-1:0]            wr_en,
    output logic [CODE_LEN_BITS:0]      wr_addr,
    output logic [LANES*SAMPLE_W-1:0]   wr_data,
    output logic                        wr_done,
    output logic                        mod_done,
    input  logic                        demod_receive,
    input  logic                        demod_done,
    output logic                        demod_done_ack,
    output logic [CODE_LEN-1:0]         code_hold,
    output logic [15:0]                 frame_cnt
);

    localparam int AW = CODE_LEN_BITS + 1;

    state_t                      state_q,      state_d;
    logic [CODE_LEN-1:0]         code_hold_q,  code_hold_d;
    logic [AW-1:0]               addr_q,       addr_d;
    logic [LANES-1:0]            wr_en_q,      wr_en_d;
    logic [AW-1:0]               wr_addr_q,    wr_addr_d;
    logic [LANES*SAMPLE_W-1:0]   wr_data_q,    wr_data_d;
    logic                        wr_done_q,    wr_done_d;
    logic                        mod_done_q,   mod_done_d;
    logic                        code_ready_q, code_ready_d;
    logic                        ack_q,        ack_d;
    logic [15:0]                 frame_cnt_q,  frame_cnt_d;

    logic [LANES-1:0]            lane_en;
    logic [LANES-1:0]            lane_bit;
    logic [LANES*SAMPLE_W-1:0]   lane_sample;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [AW:0] idx;
        assign idx        = {1'b0, addr_q} + (AW+1)'(k);
        assign lane_en[k]  = (idx < (AW+1)'(CODE_LEN));
        assign lane_bit[k] = lane_en[k] ? code_hold_q[idx[CODE_LEN_BITS-1:0]] : 1'b0;

        bpsk_lane #(
            .SAMPLE_W (SAMPLE_W),
            .FRAC_W   (FRAC_W)
        ) u_lane (
            .code_bit (lane_bit[k]),
            .noise    (noise_data[k*SAMPLE_W +: SAMPLE_W]),
            .sample   (lane_sample[k*SAMPLE_W +: SAMPLE_W])
        );
    end

    // Next-state logic: frame acceptance, per-beat write generation, frame handoff.
    always_comb begin
        state_d      = state_q;
        code_hold_d  = code_hold_q;
        addr_d       = addr_q;
        wr_en_d      = '0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_done_d    = wr_done_q;
        mod_done_d   = mod_done_q;
        code_ready_d = 1'b0;
        ack_d        = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (code_valid && noise_valid) begin
                    code_hold_d  = code_data;
                    code_ready_d = 1'b1;
                    addr_d       = '0;
                    wr_addr_d    = '0;
                    state_d      = MAP;
                end
            end
            MAP: begin
                // addr_q past the end means the last beat was issued on the
                // previous cycle; this cycle closes the frame.
                if (addr_q >= AW'(CODE_LEN)) begin
                    wr_addr_d  = '0;
                    wr_done_d  = 1'b1;
                    mod_done_d = 1'b1;
                    addr_d     = '0;
                    state_d    = DONE;
                end else if (noise_valid) begin
                    wr_en_d   = lane_en;
                    wr_addr_d = addr_q;
                    wr_data_d = lane_sample;
                    addr_d    = addr_q + AW'(LANES);
                end
            end
            DONE: begin
                if (demod_receive) begin
                    mod_done_d = 1'b0;
                end
                if (demod_done) begin
                    ack_d       = 1'b1;
                    wr_done_d   = 1'b0;
                    mod_done_d  = 1'b0;
                    code_hold_d = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; async active-low clear wins over everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            code_hold_q  <= '0;
            addr_q       <= '0;
            wr_en_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_done_q    <= 1'b0;
            mod_done_q   <= 1'b0;
            code_ready_q <= 1'b0;
            ack_q        <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            code_hold_q  <= code_hold_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_done_q    <= wr_done_d;
            mod_done_q   <= mod_done_d;
            code_ready_q <= code_ready_d;
            ack_q        <= ack_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign code_ready     = code_ready_q;
    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign wr_done        = wr_done_q;
    assign mod_done       = mod_done_q;
    assign demod_done_ack = ack_q;
    assign code_hold      = code_hold_q;
    assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_bpsk_awgn_mapper_nlane.sv
// Self-checking bench for bpsk_awgn_mapper_nlane (LANES=3, CODE_LEN=256).
// Expected samples come from integer arithmetic on the mapping rule; written
// samples are collected into a RAM image and compared per address.
module tb_bpsk_awgn_mapper_nlane;

  localparam int CL     = 256;
  localparam int CLB    = 8;
  localparam int LN     = 3;
  localparam int SW     = 15;
  localparam int FW     = 10;
  localparam int NBEATS = (CL + LN - 1) / LN;
  localparam int ONE    = 1 << FW;
  localparam int MAXV   = (1 << (SW - 1)) - 1;
  localparam int MINV   = -(1 << (SW - 1));

  logic              clk = 1'b0;
  logic              rst;
  logic              code_valid;
  logic [CL-1:0]     code_data;
  logic              code_ready;
  logic              noise_valid;
  logic [LN*SW-1:0]  noise_data;
  logic [LN-1:0]     wr_en;
  logic [CLB:0]      wr_addr;
  logic [LN*SW-1:0]  wr_data;
  logic              wr_done;
  logic              mod_done;
  logic              demod_receive;
  logic              demod_done;
  logic              demod_done_ack;
  logic [CL-1:0]     code_hold;
  logic [15:0]       frame_cnt;

  int errors = 0;
  int checks = 0;

  logic [SW-1:0] exp_ram [CL];
  logic [SW-1:0] got_ram [CL];
  int            wcnt    [CL];
  logic [CL-1:0] cur_cw;
  int            map_cycles;
  logic [CLB:0]  last_addr;
  logic [LN-1:0] last_en;
  logic [15:0]   exp_frames;

  task automatic chk(input string tag, input logic [CL-1:0] obs, input logic [CL-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  bpsk_awgn_mapper_nlane #(
    .CODE_LEN      (CL),
    .CODE_LEN_BITS (CLB),
    .LANES         (LN),
    .SAMPLE_W      (SW),
    .FRAC_W        (FW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .code_valid     (code_valid),
    .code_data      (code_data),
    .code_ready     (code_ready),
    .noise_valid    (noise_valid),
    .noise_data     (noise_data),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_done        (wr_done),
    .mod_done       (mod_done),
    .demod_receive  (demod_receive),
    .demod_done     (demod_done),
    .demod_done_ack (demod_done_ack),
    .code_hold      (code_hold),
    .frame_cnt      (frame_cnt)
  );

  always #5 clk = ~clk;

  // Reference: +/-1.0 plus signed noise, then saturate or wrap to SW bits.
  function automatic logic [SW-1:0] model_sample(input logic b, input logic [SW-1:0] n);
    int s;
    s = (b ? -ONE : ONE) + int'($signed(n));
`ifdef MOD_SAT_EN
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
`endif
    return SW'(s);
  endfunction

  function automatic logic [CL-1:0] rand_cw();
    logic [CL-1:0] v;
    for (int unsigned w = 0; w < CL / 32; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [CL-1:0] cw);
    cur_cw      = cw;
    code_data   = cw;
    code_valid  = 1'b1;
    noise_valid = 1'b1;
    noise_data  = {$urandom, $urandom};
    tick();
    chk("code_ready", code_ready, 1'b1);
    chk("code_hold", code_hold, cw);
    chk("ack_idle", demod_done_ack, 1'b0);
    chk("wr_addr_start", wr_addr, 9'd0);
    code_valid = 1'b0;
    code_data  = rand_cw();
    for (int unsigned i = 0; i < CL; i++) begin
      wcnt[i]    = 0;
      exp_ram[i] = 'x;
      got_ram[i] = 'x;
    end
    last_addr  = '0;
    last_en    = '0;
    map_cycles = 0;
  endtask

  // nv_mode: 0 always, 1 toggling, 2 random. nz_mode: 0 zero, 1 random, 2 all 0x3FFF.
  // stop_after > 0 returns right after that many beats (used for mid-frame reset).
  task automatic map_frame(input int nv_mode, input int nz_mode, input int stop_after);
    int            issued;
    bit            beat;
    logic [LN-1:0] exp_en;
    issued = 0;
    while (issued < NBEATS && map_cycles < 8 * NBEATS + 50) begin
      case (nv_mode)
        0:       noise_valid = 1'b1;
        1:       noise_valid = (map_cycles % 2 == 0);
        default: noise_valid = 1'($urandom_range(0, 1));
      endcase
      for (int unsigned k = 0; k < LN; k++) begin
        case (nz_mode)
          0:       noise_data[k*SW +: SW] = '0;
          1:       noise_data[k*SW +: SW] = SW'($urandom);
          default: noise_data[k*SW +: SW] = 15'h3FFF;
        endcase
      end
      beat   = noise_valid;
      exp_en = '0;
      if (beat) begin
        for (int unsigned k = 0; k < LN; k++) begin
          if (issued * LN + k < CL) begin
            exp_en[k] = 1'b1;
            exp_ram[issued * LN + k] =
              model_sample(cur_cw[issued * LN + k], noise_data[k*SW +: SW]);
          end
        end
      end
      tick();
      map_cycles++;
      chk("mod_done_map", mod_done, 1'b0);
      chk("wr_done_map", wr_done, 1'b0);
      if (beat) begin
        chk("wr_en_beat", wr_en, exp_en);
        chk("wr_addr_beat", wr_addr, 9'(issued * LN));
        for (int unsigned k = 0; k < LN; k++) begin
          if (wr_en[k] === 1'b1 && int'(wr_addr) + k < CL) begin
            got_ram[int'(wr_addr) + k] = wr_data[k*SW +: SW];
            wcnt[int'(wr_addr) + k]++;
          end
        end
        last_addr = wr_addr;
        last_en   = wr_en;
        issued++;
        if (stop_after > 0 && issued == stop_after) return;
      end else begin
        chk("wr_en_stall", wr_en, 3'b000);
        chk("wr_addr_hold", wr_addr, 9'(issued > 0 ? (issued - 1) * LN : 0));
      end
    end
    checks++;
    if (issued != NBEATS) begin
      errors++;
      $error("FAIL map_no_timeout: wait expired after %0d cycles, issued=%0d expected=%0d",
             map_cycles, issued, NBEATS);
    end
    noise_valid = 1'b0;
    tick();
    map_cycles++;
    chk("done_wr_en", wr_en, 3'b000);
    chk("done_wr_addr", wr_addr, 9'd0);
    chk("done_wr_done", wr_done, 1'b1);
    chk("done_mod_done", mod_done, 1'b1);
    for (int unsigned i = 0; i < CL; i++) begin
      chk("ram_write_count", wcnt[i], 1);
      chk("ram_sample", got_ram[i], exp_ram[i]);
    end
  endtask

  // mode 0: demod_receive and demod_done together. mode 1: separated, with
  // a code_valid offered during DONE that must be ignored.
  task automatic finish_frame(input int mode);
    if (mode == 0) begin
      demod_receive = 1'b1;
      demod_done    = 1'b1;
      tick();
    end else begin
      code_valid  = 1'b1;
      noise_valid = 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
        tick();
        chk("done_ignores_code", code_ready, 1'b0);
        chk("done_hold_mod", mod_done, 1'b1);
      end
      code_valid    = 1'b0;
      demod_receive = 1'b1;
      tick();
      chk("recv_mod_done", mod_done, 1'b0);
      chk("recv_wr_done", wr_done, 1'b1);
      chk("recv_no_ack", demod_done_ack, 1'b0);
      demod_receive = 1'b0;
      demod_done    = 1'b1;
      tick();
    end
    exp_frames = exp_frames + 16'd1;
    chk("rel_mod_done", mod_done, 1'b0);
    chk("rel_wr_done", wr_done, 1'b0);
    chk("rel_ack", demod_done_ack, 1'b1);
    chk("rel_code_hold", code_hold, {CL{1'b0}});
    chk("rel_frame_cnt", frame_cnt, exp_frames);
    demod_receive = 1'b0;
    demod_done    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_code_ready"}, code_ready, 1'b0);
    chk({tag, "_wr_en"}, wr_en, 3'b000);
    chk({tag, "_wr_addr"}, wr_addr, 9'd0);
    chk({tag, "_wr_data"}, wr_data, {(LN*SW){1'b0}});
    chk({tag, "_wr_done"}, wr_done, 1'b0);
    chk({tag, "_mod_done"}, mod_done, 1'b0);
    chk({tag, "_ack"}, demod_done_ack, 1'b0);
    chk({tag, "_code_hold"}, code_hold, {CL{1'b0}});
    chk({tag, "_frame_cnt"}, frame_cnt, 16'd0);
  endtask

  initial begin
    rst           = 1'b0;
    code_valid    = 1'b0;
    code_data     = '0;
    noise_valid   = 1'b0;
    noise_data    = '0;
    demod_receive = 1'b0;
    demod_done    = 1'b0;
    exp_frames    = '0;

    // Reset state.
    #12;
    check_all_zero("reset");
    tick();
    rst = 1'b1;
    tick();

    // All-zero codeword, zero noise, continuous noise: every sample +1.0.
    start_frame({CL{1'b0}});
    map_frame(0, 0, 0);
    chk("latency_continuous", map_cycles, NBEATS + 1);
    chk("zero_cw_sample0", got_ram[0], 15'h0400);
    finish_frame(0);

    // All-ones codeword: partial last beat at 255 with only lane 0 enabled.
    start_frame({CL{1'b1}});
    map_frame(0, 0, 0);
    chk("last_beat_addr", last_addr, 9'd255);
    chk("last_beat_en", last_en, 3'b001);
    chk("last_beat_data", got_ram[255], 15'h7C00);
    finish_frame(1);

    // Toggling noise_valid doubles the frame length.
    start_frame(rand_cw());
    map_frame(1, 1, 0);
    chk("latency_toggle", map_cycles, 2 * NBEATS);
    finish_frame(0);

    // Random stalls and random noise.
    start_frame(rand_cw());
    map_frame(2, 1, 0);
    finish_frame(1);

    // Large positive noise on +1.0: overflow behaviour of the sum.
    start_frame({CL{1'b0}});
    map_frame(0, 2, 0);
`ifdef MOD_SAT_EN
    chk("overflow_sample", got_ram[0], 15'h3FFF);
`else
    chk("overflow_sample", got_ram[0], 15'h43FF);
`endif
    finish_frame(0);

    // Reset asserted mid-cycle after 50 beats: outputs clear without a clock.
    start_frame(rand_cw());
    map_frame(0, 1, 50);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_frames = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_all_zero("post_reset");

    // Next frame restarts from address 0 and is the first counted frame.
    start_frame(rand_cw());
    map_frame(2, 1, 0);
    finish_frame(0);
    tick();
    chk("ack_single_pulse", demod_done_ack, 1'b0);
    chk("final_frame_cnt", frame_cnt, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
